// File: rtl/usb_fs_pkg.sv
// Shared types and constants for the full-speed USB receive path.
package usb_fs_pkg;

    // Encodings are the raw {dp, dm} line sample.
    typedef enum logic [1:0] {
        LS_SE0 = 2'b00,
        LS_K   = 2'b01,
        LS_J   = 2'b10,
        LS_SE1 = 2'b11
    } line_state_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PID,
        ST_DATA,
        ST_EOP,
        ST_ERR
    } rx_state_e;

    // Hunt register shifts in at the LSB, so the first wire bit ends up in bit 7.
    localparam logic [7:0] SYNC_PATTERN = 8'b0000_0001;

    localparam int ERR_PID   = 0;
    localparam int ERR_STUFF = 1;
    localparam int ERR_LEN   = 2;

    localparam int STUFF_RUN = 6;

    function automatic logic pid_ok(input logic [7:0] pid_byte);
        return pid_byte[7:4] == ~pid_byte[3:0];
    endfunction

endpackage

// File: rtl/usb_nrzi_unstuff.sv
// NRZI decoder with bit-unstuffing; outputs are valid in the strobe cycle.
module usb_nrzi_unstuff
    import usb_fs_pkg::*;
(
    input  logic        clk,
    input  logic        srst,
    input  logic        stb_i,
    input  line_state_e line_i,
    input  logic        unstuff_en_i,
    output logic        bit_o,
    output logic        bit_vld_o,
    output logic        stuff_err_o
);

    line_state_e prev_q, prev_d;
    logic [2:0]  ones_q, ones_d;
    logic        is_jk;
    logic        stuffed;

    always_comb begin
        is_jk       = (line_i == LS_J) || (line_i == LS_K);
        // Run length keeps counting while hunting so the SYNC's trailing 1 counts.
        stuffed     = unstuff_en_i && (ones_q == 3'(STUFF_RUN));
        bit_o       = (line_i == prev_q);
        bit_vld_o   = stb_i && is_jk && !stuffed;
        stuff_err_o = stb_i && is_jk && stuffed && bit_o;

        prev_d = prev_q;
        ones_d = ones_q;
        if (stb_i) begin
            if (!is_jk) begin
                ones_d = '0;
            end else begin
                prev_d = line_i;
                if (stuffed || !bit_o) begin
                    ones_d = '0;
                end else if (ones_q != 3'(STUFF_RUN)) begin
                    ones_d = ones_q + 3'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            prev_q <= LS_J;
            ones_q <= '0;
        end else begin
            prev_q <= prev_d;
            ones_q <= ones_d;
        end
    end

endmodule

// File: rtl/usb_fs_rx_ctrl.sv
// Full-speed USB packet receiver: SYNC hunt, PID check, byte assembly, EOP and error recovery.
module usb_fs_rx_ctrl
    import usb_fs_pkg::*;
#(
    parameter int MAX_BYTES = 1027
) (
    input  logic        UTMI_clk,
    input  logic        Rst,
    input  logic        rx_en_i,
    input  logic        bit_stb_i,
    input  logic        dp_i,
    input  logic        dm_i,
    output logic        rx_active_o,
    output logic [7:0]  rx_data_o,
    output logic        rx_valid_o,
    output logic [3:0]  pid_o,
    output logic        pid_valid_o,
    output logic [10:0] byte_cnt_o,
    output logic        eop_o,
    output logic [2:0]  err_o
);

    rx_state_e   state_q, state_d;
    logic [7:0]  hunt_q, hunt_d;
    logic [3:0]  hunt_cnt_q, hunt_cnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [2:0]  err_q, err_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic [3:0]  pid_q, pid_d;
    logic [2:0]  j_cnt_q, j_cnt_d;
    logic        rx_valid_q, rx_valid_d;
    logic        pid_valid_q, pid_valid_d;
    logic        eop_q, eop_d;

    line_state_e line;
    logic        unstuff_en;
    logic        dec_bit;
    logic        dec_vld;
    logic        dec_stuff_err;
    logic [7:0]  hunt_nxt;
    logic [7:0]  byte_nxt;

    assign line       = line_state_e'({dp_i, dm_i});
    assign unstuff_en = (state_q == ST_PID) || (state_q == ST_DATA);
    assign hunt_nxt   = {hunt_q[6:0], dec_bit};
    assign byte_nxt   = {dec_bit, shift_q[7:1]};

    usb_nrzi_unstuff u_nrzi (
        .clk          (UTMI_clk),
        .srst         (Rst),
        .stb_i        (bit_stb_i),
        .line_i       (line),
        .unstuff_en_i (unstuff_en),
        .bit_o        (dec_bit),
        .bit_vld_o    (dec_vld),
        .stuff_err_o  (dec_stuff_err)
    );

    always_comb begin
        state_d     = state_q;
        hunt_d      = hunt_q;
        hunt_cnt_d  = hunt_cnt_q;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        byte_cnt_d  = byte_cnt_q;
        err_d       = err_q;
        rx_data_d   = rx_data_q;
        pid_d       = pid_q;
        j_cnt_d     = j_cnt_q;
        rx_valid_d  = 1'b0;
        pid_valid_d = 1'b0;
        eop_d       = 1'b0;

        // Hunting restarts from scratch every time IDLE is re-entered.
        if (state_q != ST_IDLE) begin
            hunt_d     = '0;
            hunt_cnt_d = '0;
        end
        if (state_q != ST_ERR) begin
            j_cnt_d = '0;
        end

        if (!rx_en_i) begin
            state_d    = ST_IDLE;
            hunt_d     = '0;
            hunt_cnt_d = '0;
        end else if (bit_stb_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (dec_vld) begin
                        hunt_d = hunt_nxt;
                        if (hunt_cnt_q != 4'd8) begin
                            hunt_cnt_d = hunt_cnt_q + 4'd1;
                        end
                        if (hunt_cnt_q >= 4'd7 && hunt_nxt == SYNC_PATTERN) begin
                            state_d    = ST_PID;
                            err_d      = '0;
                            byte_cnt_d = '0;
                            bit_cnt_d  = '0;
                        end
                    end
                end
                ST_PID, ST_DATA: begin
                    if (line == LS_SE0) begin
                        if (bit_cnt_q != 3'd0) begin
                            err_d[ERR_STUFF] = 1'b1;
                            state_d          = ST_ERR;
                        end else begin
                            state_d = ST_EOP;
                        end
                    end else if (line == LS_SE1 || dec_stuff_err) begin
                        err_d[ERR_STUFF] = 1'b1;
                        state_d          = ST_ERR;
                    end else if (dec_vld) begin
                        shift_d   = byte_nxt;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_cnt_q == 11'(MAX_BYTES)) begin
                                err_d[ERR_LEN] = 1'b1;
                                state_d        = ST_ERR;
                            end else begin
                                rx_valid_d = 1'b1;
                                rx_data_d  = byte_nxt;
                                byte_cnt_d = byte_cnt_q + 11'd1;
                                state_d    = ST_DATA;
                                if (state_q == ST_PID) begin
                                    if (pid_ok(byte_nxt)) begin
                                        pid_d       = byte_nxt[3:0];
                                        pid_valid_d = 1'b1;
                                    end else begin
                                        err_d[ERR_PID] = 1'b1;
                                    end
                                end
                            end
                        end
                    end
                end
                ST_EOP: begin
                    case (line)
                        LS_J: begin
                            eop_d   = 1'b1;
                            state_d = ST_IDLE;
                        end
                        LS_SE0:  state_d = ST_EOP;
                        default: state_d = ST_ERR;
                    endcase
                end
                ST_ERR: begin
                    if (line == LS_J) begin
                        if (j_cnt_q == 3'd7) begin
                            state_d = ST_IDLE;
                        end else begin
                            j_cnt_d = j_cnt_q + 3'd1;
                        end
                    end else begin
                        j_cnt_d = '0;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge UTMI_clk) begin
        if (Rst) begin
            state_q     <= ST_IDLE;
            hunt_q      <= '0;
            hunt_cnt_q  <= '0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            err_q       <= '0;
            rx_data_q   <= '0;
            pid_q       <= '0;
            j_cnt_q     <= '0;
            rx_valid_q  <= 1'b0;
            pid_valid_q <= 1'b0;
            eop_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hunt_q      <= hunt_d;
            hunt_cnt_q  <= hunt_cnt_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            err_q       <= err_d;
            rx_data_q   <= rx_data_d;
            pid_q       <= pid_d;
            j_cnt_q     <= j_cnt_d;
            rx_valid_q  <= rx_valid_d;
            pid_valid_q <= pid_valid_d;
            eop_q       <= eop_d;
        end
    end

    assign rx_active_o = (state_q == ST_PID) || (state_q == ST_DATA) || (state_q == ST_EOP);
    assign rx_data_o   = rx_data_q;
    assign rx_valid_o  = rx_valid_q;
    assign pid_o       = pid_q;
    assign pid_valid_o = pid_valid_q;
    assign byte_cnt_o  = byte_cnt_q;
    assign eop_o       = eop_q;
    assign err_o       = err_q;

endmodule

// File: doc/usb_fs_rx_ctrl.md
USB_FS_RX_CTRL -- requirements
Module: usb_fs_rx_ctrl

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 1027, meaning the maximum number of bytes per packet, PID included.
REQ-002 SHALL have port UTMI_clk  input  1  single clock; all logic on its rising edge.
REQ-003 SHALL have port Rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rx_en_i  input  1  receiver enable; low forces IDLE.
REQ-005 SHALL have port bit_stb_i  input  1  one-cycle strobe marking the sample point of one FS bit (12 Mb/s).
REQ-006 SHALL have port dp_i  input  1  D+ line sample.
REQ-007 SHALL have port dm_i  input  1  D- line sample.
REQ-008 SHALL have port rx_active_o  output  1  high from SYNC detected to packet end.
REQ-009 SHALL have port rx_data_o  output  8  last assembled byte, LSB first on the wire.
REQ-010 SHALL have port rx_valid_o  output  1  one-cycle pulse per byte, PID included.
REQ-011 SHALL have port pid_o  output  4  PID nibble of the current packet.
REQ-012 SHALL have port pid_valid_o  output  1  one-cycle pulse when the PID byte passes its check.
REQ-013 SHALL have port byte_cnt_o  output  11  bytes received in the current packet.
REQ-014 SHALL have port eop_o  output  1  one-cycle pulse on a clean end of packet.
REQ-015 SHALL have port err_o  output  3  sticky per packet: {len_err, stuff_err, pid_err}; cleared on the next SYNC.

Function
REQ-016 Line states SHALL decode as J={dp,dm}=10, K=01, SE0=00, SE1=11; SE1 SHALL be treated as an error.
REQ-017 State and shift registers SHALL update only in cycles with bit_stb_i=1; pulse outputs SHALL be low otherwise.
REQ-018 NRZI decode SHALL be: no change from the previous non-SE0 line state = 1; change = 0; the previous state after reset is J.
REQ-019 FSM states SHALL be IDLE, PID, DATA, EOP, ERR.
- IDLE: shift decoded bits into an 8-bit hunt register.
- IDLE -> PID: when the hunt register equals SYNC (wire order 0000_0001, i.e. KJKJKJKK); set rx_active_o, clear err_o and byte_cnt_o.
REQ-020 Bit unstuffing SHALL work as follows:
- After six consecutive decoded 1s, the next bit SHALL be dropped.
- If that bit is a 1, set stuff_err and go to ERR.
REQ-021 PID state SHALL assemble 8 bits, then:
- Pulse rx_valid_o.
- If data[7:4]==~data[3:0], load pid_o and pulse pid_valid_o.
- Otherwise set pid_err.
- Go to DATA in either case.
REQ-022 DATA SHALL pulse rx_valid_o on each 8th unstuffed bit and increment byte_cnt_o; if byte_cnt_o would exceed MAX_BYTES, set len_err and go to ERR.
REQ-023 On SE0 in PID or DATA, go to EOP; a partial byte (bit count != 0) SHALL set stuff_err.
REQ-024 In EOP, SE0 followed by J SHALL pulse eop_o, drop rx_active_o, and return to IDLE; K or SE1 SHALL go to ERR.
REQ-025 ERR SHALL hold rx_active_o low and wait for J on 8 consecutive bits, then go to IDLE.
REQ-026 rx_valid_o, pid_valid_o and eop_o SHALL rise in the cycle after the bit_stb_i that completed the event (1-cycle latency).
REQ-027 On rx_en_i low in any state: next cycle go to IDLE, rx_active_o=0, no pulses, err_o retained.
REQ-028 A SYNC arriving in the same bit as an EOP completion SHALL be ignored; the hunt register SHALL restart after the EOP.

Reset
REQ-029 On Rst=1 at a clock edge:
- state=IDLE.
- rx_active_o, rx_valid_o, pid_valid_o and eop_o = 0.
- rx_data_o=8'h00, pid_o=4'h0, byte_cnt_o=0, err_o=3'b000.
- Hunt register and ones-counter = 0; previous line state = J.
REQ-030 Reset mid-packet SHALL abort with no eop_o pulse.

Structure
REQ-031 A shared package usb_fs_pkg SHALL hold the line-state enum, FSM state enum, the SYNC constant, and the error-bit index constants.
REQ-032 A sub-module usb_nrzi_unstuff SHALL contain the NRZI decode and bit-unstuff logic and output {bit, bit_vld, stuff_err}; the FSM and byte assembly stay in the top.

Verification
REQ-033 SYNC, then ACK byte 8'b11010010, then SE0,SE0,J -> one rx_valid_o with rx_data_o=8'hD2, pid_valid_o with pid_o=4'h2, eop_o, byte_cnt_o=1, err_o=0.
REQ-034 PID byte 8'hD3 -> rx_valid_o pulses, no pid_valid_o, err_o=3'b001, and the packet still ends with eop_o.
REQ-035 Data byte 8'hFF with its stuffed 0 -> rx_data_o=8'hFF, no error; the same byte with the stuffed bit forced to 1 -> err_o=3'b010 and the FSM goes to ERR.
REQ-036 SE0 after 3 data bits -> err_o[1]=1, no eop_o pulse.
REQ-037 rx_en_i dropped after the PID -> rx_active_o low next cycle; a following full packet is received normally.
REQ-038 With MAX_BYTES=4 and 5 bytes sent -> len_err set at the 5th byte, 4 rx_valid_o pulses in total.
